control_contador_escritura: RTL and testbench

Write-cycle sequencer for the RTC's multiplexed AD[7:0] bus, and the counterpart of the read-cycle controller.
It runs one complete RTC write transaction: an address phase, a bus-turnaround gap, then a data phase.
It drives CS_n, WR_n, RD_n and the A/D select, plus the tristate enable and output value for AD.
It sits between the top-level control FSM, which supplies register address and data, and the RTC pin interface.

---
 rtl/escritura_pkg.sv | 25 ++
 rtl/control_contador_escritura_if.sv | 26 ++
 rtl/contador_fase_escritura.sv | 25 ++
 rtl/control_contador_escritura.sv | 139 +++++++++++++
 tb/tb_control_contador_escritura.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/escritura_pkg.sv
// Shared definitions for the RTC write-cycle sequencer: state encoding,
// default timing and the A/D select encoding common to read and write paths.
package escritura_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_A_SETUP  = 4'd1,
    S_A_STROBE = 4'd2,
    S_A_HOLD   = 4'd3,
    S_GAP      = 4'd4,
    S_D_SETUP  = 4'd5,
    S_D_STROBE = 4'd6,
    S_D_HOLD   = 4'd7,
    S_DONE     = 4'd8
  } estado_t;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 10;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_GAP_DEF   = 8;

  localparam logic AD_SEL_ADDR = 1'b0;
  localparam logic AD_SEL_DATA = 1'b1;

endpackage

// File: rtl/control_contador_escritura_if.sv
// Request side (from the control FSM) and pin side (to the RTC) of the
// write sequencer, bundled so both ends share one definition.
interface control_contador_escritura_if;
  logic       EnE;
  logic       LecBusy;
  logic [7:0] DirE;
  logic [7:0] DatoE;
  logic [7:0] AD_out;
  logic       AD_oe;
  logic       AD_sel;
  logic       CS_n;
  logic       WR_n;
  logic       RD_n;
  logic       Busy;
  logic       Done;

  modport master (
    output EnE, LecBusy, DirE, DatoE,
    input  AD_out, AD_oe, AD_sel, CS_n, WR_n, RD_n, Busy, Done
  );

  modport slave (
    input  EnE, LecBusy, DirE, DatoE,
    output AD_out, AD_oe, AD_sel, CS_n, WR_n, RD_n, Busy, Done
  );
endinterface

// File: rtl/contador_fase_escritura.sv
// 8-bit loadable down-counter timing each phase; last flags the final cycle
// of the current state so the FSM can advance on the following edge.
module contador_fase_escritura (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic       last
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != 8'd0) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign last = (count_q == 8'd1);

endmodule

// File: rtl/control_contador_escritura.sv
// RTC write-cycle sequencer: address phase, released-bus gap, data phase.
// All pins are registered and decoded from the next state.
module control_contador_escritura
  import escritura_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic                          clkE,
  input  logic                          resetE,
  control_contador_escritura_if.slave   bus
);

  if (T_SETUP < 1 || T_SETUP > 255 || T_PULSE < 1 || T_PULSE > 255 ||
      T_HOLD  < 1 || T_HOLD  > 255 || T_GAP   < 1 || T_GAP   > 255) begin : g_param_check
    $error("control_contador_escritura: timing parameters must lie in 1..255");
  end

  estado_t    state_q, state_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] dato_q, dato_d;
  logic       last;
  logic       load;
  logic [7:0] load_val;

  logic [7:0] ad_out_q;
  logic       ad_oe_q, ad_sel_q, cs_n_q, wr_n_q, busy_q, done_q;

  function automatic logic [7:0] duracion(estado_t s);
    logic [7:0] d;
    case (s)
      S_A_SETUP, S_D_SETUP:   d = 8'(T_SETUP);
      S_A_STROBE, S_D_STROBE: d = 8'(T_PULSE);
      S_A_HOLD, S_D_HOLD:     d = 8'(T_HOLD);
      S_GAP:                  d = 8'(T_GAP);
      default:                d = 8'd0;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    dato_d  = dato_q;
    case (state_q)
      S_IDLE: begin
        if (bus.EnE && !bus.LecBusy) begin
          state_d = S_A_SETUP;
          dir_d   = bus.DirE;
          dato_d  = bus.DatoE;
        end
      end
      S_A_SETUP:  if (last) state_d = S_A_STROBE;
      S_A_STROBE: if (last) state_d = S_A_HOLD;
      S_A_HOLD:   if (last) state_d = S_GAP;
      S_GAP:      if (last) state_d = S_D_SETUP;
      S_D_SETUP:  if (last) state_d = S_D_STROBE;
      S_D_STROBE: if (last) state_d = S_D_HOLD;
      S_D_HOLD:   if (last) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    // Counter reloads on every state entry so each state lasts exactly its duration.
    load     = (state_d != state_q);
    load_val = duracion(state_d);
  end

  contador_fase_escritura u_contador (
    .clk   (clkE),
    .rst_n (resetE),
    .load  (load),
    .value (load_val),
    .last  (last)
  );

  always_ff @(posedge clkE or negedge resetE) begin
    if (!resetE) begin
      state_q  <= S_IDLE;
      dir_q    <= 8'd0;
      dato_q   <= 8'd0;
      ad_out_q <= 8'd0;
      ad_oe_q  <= 1'b0;
      ad_sel_q <= AD_SEL_ADDR;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      dato_q   <= dato_d;
      ad_out_q <= 8'd0;
      ad_oe_q  <= 1'b0;
      ad_sel_q <= AD_SEL_ADDR;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      case (state_d)
        S_A_SETUP, S_A_HOLD: begin
          ad_out_q <= dir_d;
          ad_oe_q  <= 1'b1;
        end
        S_A_STROBE: begin
          ad_out_q <= dir_d;
          ad_oe_q  <= 1'b1;
          cs_n_q   <= 1'b0;
          wr_n_q   <= 1'b0;
        end
        S_GAP: ad_sel_q <= AD_SEL_DATA;
        S_D_SETUP, S_D_HOLD: begin
          ad_out_q <= dato_d;
          ad_oe_q  <= 1'b1;
          ad_sel_q <= AD_SEL_DATA;
        end
        S_D_STROBE: begin
          ad_out_q <= dato_d;
          ad_oe_q  <= 1'b1;
          ad_sel_q <= AD_SEL_DATA;
          cs_n_q   <= 1'b0;
          wr_n_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.AD_out = ad_out_q;
  assign bus.AD_oe  = ad_oe_q;
  assign bus.AD_sel = ad_sel_q;
  assign bus.CS_n   = cs_n_q;
  assign bus.WR_n   = wr_n_q;
  assign bus.RD_n   = 1'b1;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;

endmodule

// File: tb/tb_control_contador_escritura.sv
// Drives a default-timing and a minimum-timing sequencer with the same inputs
// and compares every cycle against a phase-arithmetic model of the write cycle.
module tb_control_contador_escritura;

  localparam int SA = 2, PA = 10, HA = 2, GA = 8;
  localparam int SB = 1, PB = 1, HB = 1, GB = 1;
  // {AD_out[7:0], AD_oe, AD_sel, CS_n, WR_n, RD_n, Busy, Done}
  localparam logic [14:0] IDLE_PINS = {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic       clkE   = 1'b0;
  logic       resetE = 1'b0;
  logic       en     = 1'b0;
  logic       lec    = 1'b0;
  logic [7:0] dir    = 8'h00;
  logic [7:0] dato   = 8'h00;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit         valid [2];
  int         start [2];
  logic [7:0] mdir  [2];
  logic [7:0] mdato [2];

  control_contador_escritura_if if_a ();
  control_contador_escritura_if if_b ();

  assign if_a.EnE = en;  assign if_a.LecBusy = lec;  assign if_a.DirE = dir;  assign if_a.DatoE = dato;
  assign if_b.EnE = en;  assign if_b.LecBusy = lec;  assign if_b.DirE = dir;  assign if_b.DatoE = dato;

  control_contador_escritura #(.T_SETUP(SA), .T_PULSE(PA), .T_HOLD(HA), .T_GAP(GA)) dut_a (
    .clkE(clkE), .resetE(resetE), .bus(if_a));
  control_contador_escritura #(.T_SETUP(SB), .T_PULSE(PB), .T_HOLD(HB), .T_GAP(GB)) dut_b (
    .clkE(clkE), .resetE(resetE), .bus(if_b));

  wire [14:0] pins_a = {if_a.AD_out, if_a.AD_oe, if_a.AD_sel, if_a.CS_n, if_a.WR_n, if_a.RD_n, if_a.Busy, if_a.Done};
  wire [14:0] pins_b = {if_b.AD_out, if_b.AD_oe, if_b.AD_sel, if_b.CS_n, if_b.WR_n, if_b.RD_n, if_b.Busy, if_b.Done};

  always #5 clkE = ~clkE;

  function automatic int t_s(int d); return (d == 0) ? SA : SB; endfunction
  function automatic int t_p(int d); return (d == 0) ? PA : PB; endfunction
  function automatic int t_h(int d); return (d == 0) ? HA : HB; endfunction
  function automatic int t_g(int d); return (d == 0) ? GA : GB; endfunction
  function automatic int txn_len(int d);
    return 2 * (t_s(d) + t_p(d) + t_h(d)) + t_g(d) + 1;
  endfunction
  function automatic int txn_offset(int d);
    return valid[d] ? (cyc - start[d]) : -1;
  endfunction

  // Expected pins from the position inside the transaction: phase length a, gap g, done at 2a+g+1.
  function automatic logic [14:0] exp_pins(int d);
    int k, a, kk;
    logic [7:0] ad;
    logic sel, strobe;
    k = txn_offset(d);
    a = t_s(d) + t_p(d) + t_h(d);
    if (k < 1 || k > txn_len(d)) return IDLE_PINS;
    if (k <= a) begin
      kk = k; ad = mdir[d]; sel = 1'b0;
    end else if (k <= a + t_g(d)) begin
      return {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    end else if (k <= 2 * a + t_g(d)) begin
      kk = k - a - t_g(d); ad = mdato[d]; sel = 1'b1;
    end else begin
      return {8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    end
    strobe = (kk > t_s(d)) && (kk <= t_s(d) + t_p(d));
    return {ad, 1'b1, sel, ~strobe, ~strobe, 1'b1, 1'b1, 1'b0};
  endfunction

  // AD_out is only meaningful while driven; AD_sel is unconstrained in IDLE/DONE.
  function automatic logic [14:0] pin_mask(logic [14:0] e);
    logic [14:0] m;
    m = '1;
    if (!e[6]) m[14:7] = 8'h00;
    if (!e[1] || e[0]) m[5] = 1'b0;
    return m;
  endfunction

  task automatic check_pins();
    logic [14:0] obs, e, m;
    for (int d = 0; d < 2; d++) begin
      obs = (d == 0) ? pins_a : pins_b;
      e   = exp_pins(d);
      m   = pin_mask(e);
      n_assert++;
      assert ((obs & m) === (e & m)) else begin
        n_fail++;
        $error("FAIL pins_dut%0d cycle %0d offset %0d observed=%04h expected=%04h mask=%04h",
               d, cyc, txn_offset(d), obs, e, m);
      end
    end
  endtask

  task automatic check_reset_pins(string tag);
    n_assert++;
    assert (pins_a === IDLE_PINS) else begin
      n_fail++;
      $error("FAIL %s_dut0 observed=%04h expected=%04h", tag, pins_a, IDLE_PINS);
    end
    n_assert++;
    assert (pins_b === IDLE_PINS) else begin
      n_fail++;
      $error("FAIL %s_dut1 observed=%04h expected=%04h", tag, pins_b, IDLE_PINS);
    end
  endtask

  task automatic step();
    @(posedge clkE);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (resetE && en && !lec && (!valid[d] || (cyc - 1 - start[d]) > txn_len(d))) begin
        valid[d] = 1'b1;
        start[d] = cyc - 1;
        mdir[d]  = dir;
        mdato[d] = dato;
        $display("txn dut%0d accepted at cycle %0d dir=%02h dato=%02h", d, cyc - 1, dir, dato);
      end
    end
    #1;
    check_pins();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; start[d] = 0; mdir[d] = 8'h00; mdato[d] = 8'h00;
    end

    // Reset state, checked while reset is still asserted.
    repeat (2) @(posedge clkE);
    #1;
    check_reset_pins("reset");
    #2 resetE = 1'b1;
    repeat (2) step();

    // Single transaction 0x0A / 0x5C; inputs scrambled mid address phase.
    en = 1'b1; dir = 8'h0A; dato = 8'h5C;
    step();
    en = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (txn_offset(0) == 4) begin dir = 8'hFF; dato = 8'hFF; end
      step();
    end

    // EnE held high: back-to-back transactions, requests during Busy ignored.
    en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dir = 8'($urandom); dato = 8'($urandom);
      step();
    end
    for (int i = 0; i < 60; i++) begin
      en = ($urandom_range(0, 2) == 0); dir = 8'($urandom); dato = 8'($urandom);
      step();
    end
    en = 1'b0;
    repeat (45) step();

    // LecBusy blocks the start until it drops.
    en = 1'b1; lec = 1'b1; dir = 8'h3C; dato = 8'hC3;
    repeat (20) step();
    lec = 1'b0;
    step();
    en = 1'b0;

    // Asynchronous reset in the middle of the address strobe.
    for (int i = 0; i < 10 && txn_offset(0) != 5; i++) step();
    #2 resetE = 1'b0;
    #1;
    valid[0] = 1'b0; valid[1] = 1'b0;
    check_reset_pins("async_reset");
    step();
    #2 resetE = 1'b1;
    repeat (6) step();

    // Random traffic with LecBusy interference.
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      lec  = ($urandom_range(0, 3) == 0);
      dir  = 8'($urandom);
      dato = 8'($urandom);
      step();
    end
    en = 1'b0; lec = 1'b0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
